// File: rtl/lite_to_stream_serializer.sv
// Wide-to-narrow message serializer: buffers one wide message and emits it as a
// burst of narrow beats, each carrying the header with an auto-incremented
// (wrapping) beat address.
module lite_to_stream_serializer #(
   parameter int in_data_width_p  = 64,
   parameter int out_data_width_p = 16,
   parameter int addr_width_p     = 40,
   parameter int size_width_p     = 3,
   parameter int msg_type_width_p = 4,
   parameter int misc_width_p     = 8,
   parameter logic [(1<<msg_type_width_p)-1:0] payload_mask_p = '0
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [msg_type_width_p-1:0] msg_type_i,
   input  logic [addr_width_p-1:0]     addr_i,
   input  logic [size_width_p-1:0]     size_i,
   input  logic [misc_width_p-1:0]     misc_i,
   input  logic [in_data_width_p-1:0]  data_i,
   input  logic                        v_i,
   output logic                        ready_o,
   output logic [msg_type_width_p-1:0] msg_type_o,
   output logic [addr_width_p-1:0]     addr_o,
   output logic [size_width_p-1:0]     size_o,
   output logic [misc_width_p-1:0]     misc_o,
   output logic [out_data_width_p-1:0] data_o,
   output logic                        v_o,
   input  logic                        ready_i,
   output logic                        lock_o
);

   localparam int W      = in_data_width_p / out_data_width_p;
   localparam int OB     = out_data_width_p / 8;
   localparam int OB_LOG = $clog2(OB);
   localparam int OFF    = (OB > 1) ? $clog2(OB) : 1;
   localparam int IDX    = (W > 1) ? $clog2(W) : 0;
   localparam int KW     = (IDX > 0) ? IDX : 1;

   if (in_data_width_p < out_data_width_p || (in_data_width_p % out_data_width_p) != 0) begin : g_bad_width
      $error("in_data_width_p must be a non-zero multiple of out_data_width_p");
   end

   typedef enum logic {ST_EMPTY, ST_FULL} state_e;

   state_e                      state_q, state_d;
   logic [KW-1:0]               k_q, k_d;
   logic [KW-1:0]               last_q, last_n;
   logic [msg_type_width_p-1:0] type_q;
   logic [addr_width_p-1:0]     addr_q;
   logic [size_width_p-1:0]     size_q;
   logic [misc_width_p-1:0]     misc_q;
   logic [in_data_width_p-1:0]  data_q;
   logic [31:0]                 sz;
   logic                        accept;

   assign ready_o = (state_q == ST_EMPTY) & ~reset_i;
   assign accept  = v_i & ready_o;
   assign sz      = 32'(size_i);

   // Last beat index of the incoming message: 2^size bytes split into beats, clamped to [1, W]
   always_comb begin
      last_n = '0;
      if (payload_mask_p[msg_type_i] && sz > 32'(OB_LOG)) begin
         if (sz - 32'(OB_LOG) >= 32'(IDX)) last_n = KW'(W - 1);
         else                               last_n = KW'((32'd1 << (sz - 32'(OB_LOG))) - 32'd1);
      end
   end

   // Buffer occupancy and beat counter next-state
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_FULL;
               k_d     = '0;
            end
         end
         ST_FULL: begin
            if (ready_i) begin
               if (k_q == last_q) begin
                  state_d = ST_EMPTY;
                  k_d     = '0;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
            k_d     = '0;
         end
      endcase
   end

   // Control state; reset drops any message in flight
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_EMPTY;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // Message buffer, captured on accept only
   always_ff @(posedge clk_i) begin
      if (accept) begin
         type_q <= msg_type_i;
         addr_q <= addr_i;
         size_q <= size_i;
         misc_q <= misc_i;
         data_q <= data_i;
         last_q <= last_n;
      end
   end

   assign v_o        = (state_q == ST_FULL);
   assign lock_o     = v_o & (k_q != last_q);
   assign msg_type_o = type_q;
   assign size_o     = size_q;
   assign misc_o     = misc_q;
   assign data_o     = data_q[32'(k_q) * out_data_width_p +: out_data_width_p];

   if (IDX > 0) begin : g_idx
      logic [IDX-1:0] f_q;
      logic [IDX-1:0] idx;

      // First beat index, taken from the address field that selects the beat
      always_ff @(posedge clk_i) begin
         if (accept) f_q <= addr_i[OFF +: IDX];
      end

      // Beat index wraps naturally inside the IDX-bit field
      assign idx = f_q + k_q;

      // Beat address: latched address with only the beat-index field replaced
      always_comb begin
         addr_o              = addr_q;
         addr_o[OFF +: IDX]  = idx;
      end
   end else begin : g_no_idx
      assign addr_o = addr_q;
   end

endmodule

// File: tb/tb_lite_to_stream_serializer.sv
// Directed bench: driver pushes hand-computed beats into a scoreboard queue, a
// negedge monitor pops and compares every consumed beat.
module tb_lite_to_stream_serializer;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [3:0]  msg_type_i;
   logic [39:0] addr_i;
   logic [2:0]  size_i;
   logic [7:0]  misc_i;
   logic [63:0] data_i;
   logic        v_i;
   logic        ready_o;
   logic [3:0]  msg_type_o;
   logic [39:0] addr_o;
   logic [2:0]  size_o;
   logic [7:0]  misc_o;
   logic [15:0] data_o;
   logic        v_o;
   logic        ready_i;
   logic        lock_o;

   always #5 clk = ~clk;

   lite_to_stream_serializer #(
      .in_data_width_p(64), .out_data_width_p(16), .addr_width_p(40),
      .size_width_p(3), .msg_type_width_p(4), .misc_width_p(8),
      .payload_mask_p(16'h0002)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .msg_type_i(msg_type_i), .addr_i(addr_i), .size_i(size_i), .misc_i(misc_i),
      .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
      .msg_type_o(msg_type_o), .addr_o(addr_o), .size_o(size_o), .misc_o(misc_o),
      .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .lock_o(lock_o)
   );

   typedef struct {
      logic [15:0] d;
      logic [39:0] a;
      logic        l;
      logic [3:0]  t;
      logic [2:0]  s;
      logic [7:0]  m;
   } beat_t;

   beat_t       exp_q[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [3:0]  cur_t;
   logic [2:0]  cur_s;
   logic [7:0]  cur_m;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic expb(input logic [15:0] d, input logic [39:0] a, input logic l);
      beat_t b;
      b.d = d; b.a = a; b.l = l; b.t = cur_t; b.s = cur_s; b.m = cur_m;
      exp_q.push_back(b);
   endtask

   // Monitor: every consumed beat is compared against the head of the scoreboard
   always @(negedge clk) begin
      if (v_o && ready_i) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h addr %0h, expected no beat", data_o, addr_o);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_data", 64'(data_o), 64'(e.d));
            chk("beat_addr", 64'(addr_o), 64'(e.a));
            chk("beat_lock", 64'(lock_o), 64'(e.l));
            chk("beat_type", 64'(msg_type_o), 64'(e.t));
            chk("beat_size", 64'(size_o), 64'(e.s));
            chk("beat_misc", 64'(misc_o), 64'(e.m));
         end
      end
   end

   task automatic send(input logic [3:0] t, input logic [2:0] s, input logic [39:0] a,
                       input logic [63:0] d, input logic [7:0] m);
      int n = 0;
      cur_t = t; cur_s = s; cur_m = m;
      @(negedge clk);
      while (!ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) chk("send_ready_timeout", 64'(ready_o), 64'd1);
      msg_type_i = t; size_i = s; addr_i = a; data_i = d; misc_i = m; v_i = 1'b1;
      @(posedge clk);
      #1 v_i = 1'b0;
   endtask

   // Wait for all expected beats, then the buffer must be free on the next cycle
   task automatic drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_ready_after"}, 64'(ready_o), 64'd1);
      chk({nm, "_v_after"}, 64'(v_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b1;
      msg_type_i = '0; addr_i = '0; size_i = '0; misc_i = '0; data_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_v", 64'(v_o), 64'd0);
      chk("rst_lock", 64'(lock_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd0);
      reset_i = 1'b0;
      #1 chk("rst_release_ready", 64'(ready_o), 64'd1);

      // Four-beat data message
      send(4'd1, 3'd3, 40'h100, 64'h4444_3333_2222_1111, 8'hA5);
      expb(16'h1111, 40'h100, 1'b1);
      expb(16'h2222, 40'h102, 1'b1);
      expb(16'h3333, 40'h104, 1'b1);
      expb(16'h4444, 40'h106, 1'b0);
      drain("burst4");

      // Starting index 2 wraps the beat address
      send(4'd1, 3'd3, 40'h104, 64'h4444_3333_2222_1111, 8'h3C);
      expb(16'h1111, 40'h104, 1'b1);
      expb(16'h2222, 40'h106, 1'b1);
      expb(16'h3333, 40'h100, 1'b1);
      expb(16'h4444, 40'h102, 1'b0);
      drain("wrap");

      // Type without payload is a single beat
      send(4'd0, 3'd3, 40'h100, 64'h4444_3333_2222_1111, 8'h01);
      expb(16'h1111, 40'h100, 1'b0);
      drain("nodata");

      // Size below one beat width
      send(4'd1, 3'd0, 40'h100, 64'h4444_3333_2222_1111, 8'h02);
      expb(16'h1111, 40'h100, 1'b0);
      drain("size0");

      // Two-beat message
      send(4'd1, 3'd2, 40'h100, 64'h4444_3333_2222_1111, 8'h03);
      expb(16'h1111, 40'h100, 1'b1);
      expb(16'h2222, 40'h102, 1'b0);
      drain("size2");

      // Oversized message clamps to four beats
      send(4'd1, 3'd7, 40'hFF_0000_0000, 64'h8888_7777_6666_5555, 8'h04);
      expb(16'h5555, 40'hFF_0000_0000, 1'b1);
      expb(16'h6666, 40'hFF_0000_0002, 1'b1);
      expb(16'h7777, 40'hFF_0000_0004, 1'b1);
      expb(16'h8888, 40'hFF_0000_0006, 1'b0);
      drain("clamp");

      // Backpressure after the first beat; v_i must be ignored while full
      send(4'd1, 3'd3, 40'h20, 64'hDDDD_CCCC_BBBB_AAAA, 8'h77);
      expb(16'hAAAA, 40'h20, 1'b1);
      expb(16'hBBBB, 40'h22, 1'b1);
      expb(16'hCCCC, 40'h24, 1'b1);
      expb(16'hDDDD, 40'h26, 1'b0);
      @(posedge clk);
      #1;
      ready_i = 1'b0; v_i = 1'b1; data_i = 64'hDEAD_BEEF_DEAD_BEEF; addr_i = 40'h999; misc_i = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_data", 64'(data_o), 64'hBBBB);
         chk("stall_addr", 64'(addr_o), 64'h22);
         chk("stall_lock", 64'(lock_o), 64'd1);
         chk("stall_v", 64'(v_o), 64'd1);
         chk("stall_ready", 64'(ready_o), 64'd0);
      end
      @(posedge clk);
      #1;
      ready_i = 1'b1; v_i = 1'b0;
      drain("stall");

      // Reset while beat 2 is presented
      send(4'd1, 3'd3, 40'h100, 64'h4444_3333_2222_1111, 8'h55);
      expb(16'h1111, 40'h100, 1'b1);
      expb(16'h2222, 40'h102, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("pre_reset_data", 64'(data_o), 64'h3333);
      reset_i = 1'b1; ready_i = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_v", 64'(v_o), 64'd0);
      chk("midrst_lock", 64'(lock_o), 64'd0);
      chk("midrst_ready", 64'(ready_o), 64'd0);
      reset_i = 1'b0; ready_i = 1'b1;
      #1;
      chk("postrst_ready", 64'(ready_o), 64'd1);
      chk("postrst_pending", 64'(exp_q.size()), 64'd0);

      // Fresh message after reset starts at k=0, first index 3
      send(4'd1, 3'd3, 40'h206, 64'h4444_3333_2222_1111, 8'h66);
      expb(16'h1111, 40'h206, 1'b1);
      expb(16'h2222, 40'h200, 1'b1);
      expb(16'h3333, 40'h202, 1'b1);
      expb(16'h4444, 40'h204, 1'b0);
      drain("postrst");

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lite_to_stream_serializer.md
Name: lite_to_stream_serializer

Overview:
- Converts one wide ("lite") memory message (header + in_data_width_p payload) into a burst of narrow stream beats (header + out_data_width_p data each).
- Holds the message in a one-entry buffer, serializes the payload with a dynamic-length parallel-in/serial-out, and auto-increments the beat address with a set/enable counter.
- Sits between a wide-data master and a narrow-data stream client.

Parameters:
- in_data_width_p, 64, input payload width; must be a multiple of out_data_width_p.
- out_data_width_p, 16, output beat width; multiple of 8.
- addr_width_p, 40, address field width.
- size_width_p, 3, size code width; a message covers 2^size bytes.
- msg_type_width_p, 4, message type width.
- misc_width_p, 8, opaque header bits, passed through unchanged.
- payload_mask_p, 0, bit t set means msg_type t carries data.

Derived values:
- W = in/out.
- OB = out_data_width_p/8.
- OFF = clog2(OB), minimum 1 when OB=1.
- IDX = clog2(W); 0 when W=1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- msg_type_i  in  msg_type_width_p  input message type
- addr_i  in  addr_width_p  input address
- size_i  in  size_width_p  input size code
- misc_i  in  misc_width_p  opaque header bits
- data_i  in  in_data_width_p  input payload
- v_i  in  1  input valid
- ready_o  out  1  input ready (ready-valid-and)
- msg_type_o  out  msg_type_width_p  held message type
- addr_o  out  addr_width_p  per-beat address
- size_o  out  size_width_p  held size code
- misc_o  out  misc_width_p  held misc bits
- data_o  out  out_data_width_p  current beat data
- v_o  out  1  beat valid
- ready_i  in  1  client ready
- lock_o  out  1  more beats of this message follow

Behaviour:
- Handshakes:
  - Input accepted on v_i & ready_o.
  - A beat is consumed on v_o & ready_i.
- Buffer:
  - ready_o = 1 exactly when the buffer is empty; 0 while reset_i is high.
  - No same-cycle refill: a message can be accepted at the earliest one cycle after the last beat is consumed.
- On accept, latch:
  - header fields and data_i;
  - beats N = has_data ? clamp(2^size_i / OB, 1, W) : 1, where has_data = payload_mask_p[msg_type_i];
  - beat counter k = 0;
  - first index F = addr_i[OFF +: IDX].
- Output:
  - v_o = buffer full.
  - data_o = slice k of the latched data (bits k*out .. k*out+out-1), lowest slice first.
  - addr_o = latched addr with field [OFF +: IDX] replaced by (F + k) mod W; all other bits unchanged.
  - Other header fields = latched values.
- Beat progression:
  - When a beat is consumed and k < N-1: k increments.
  - When a beat is consumed and k == N-1: buffer empties, v_o falls next cycle, ready_o rises next cycle.
- lock_o = v_o & (k != N-1).
- Combinational paths:
  - Outputs do not depend combinationally on ready_i.
  - ready_o does not depend on v_i.
- Latency: first beat is valid the cycle after accept; one beat per cycle while ready_i is held high.
- Reset: v_o=0, lock_o=0, k=0, buffer empty. Reset mid-burst discards the message.
- Stalling: ready_i low holds all outputs stable.
- W = 1: exactly 1 beat; addr_o = addr_i; lock_o = 0.
- Width rules:
  - Index arithmetic is modulo W (W a power of two).
  - A size_i beyond in_data_width_p clamps to W beats.
  - A size_i below one beat width gives 1 beat.
- Elaboration check: an error is raised if in_data_width_p < out_data_width_p or in mod out != 0.

Test Plan (in=64, out=16, W=4, OB=2, OFF=1, IDX=2, payload_mask_p=2 i.e. type 1 has data):
- Data message: type 1, size 3, addr 0x100, data 0x4444_3333_2222_1111, ready_i=1 -> four beats:
  - data 0x1111, 0x2222, 0x3333, 0x4444;
  - addr 0x100, 0x102, 0x104, 0x106;
  - lock_o 1,1,1,0;
  - ready_o returns 1 the cycle after the last beat.
- Wrapping address: same message with addr 0x104 -> addr 0x104, 0x106, 0x100, 0x102; data order unchanged (0x1111 first).
- No-data message: type 0, size 3 -> a single beat with lock_o=0 and data_o = 0x1111.
- Small message: type 1, size 0 -> 1 beat. With size 2 -> 2 beats, lock_o 1,0.
- Backpressure: ready_i low for 3 cycles mid-burst -> outputs hold, ready_o stays 0, v_i ignored; the burst resumes with no lost beats.
- Reset: assert reset_i during beat 2 -> next cycle v_o=0 and lock_o=0; ready_o=1 after reset is released; a new message then streams normally from k=0.
